// File: rtl/radix8_ntt_pkg.sv
// Shared types and helpers for the radix-8 DIF NTT sequencer.
// Lane k of a packed 8-lane bus lives at [k*LOGN +: LOGN].
package radix8_ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ntt_state_e;

  localparam int LANES    = 8;
  localparam int LANE_LOG = 3;

  // (k * j * 8^s) mod 2^logn: 8^s is a shift, the modulus is a mask
  function automatic logic [31:0] tf_exponent(input logic [31:0] k, input logic [31:0] j,
                                              input logic [31:0] s, input int logn);
    logic [31:0] prod_s;
    prod_s = (k * j) << (32'd3 * s);
    return prod_s & ((32'd1 << logn) - 32'd1);
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Valid+data shift register of depth DEPTH that holds while hold=1.
// Used to replay read issues as write-backs after the read/datapath latency.
module ntt_addr_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_r;
  logic [W-1:0]     data_r [DEPTH];

  // shift one place per non-held cycle; sync clear on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) data_r[i] <= '0;
    end else if (!hold) begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1] & ~hold;
  assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/radix8_ntt_ctrl.sv
// Radix-8 DIF NTT sequencer: one butterfly per cycle, per-stage drain so a
// stage never reads words the previous stage has not yet written back.
module radix8_ntt_ctrl
  import radix8_ntt_pkg::*;
#(
  parameter int LOGN     = 9,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 1,
  localparam int STAGES  = LOGN / 3,
  localparam int SW      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [SW-1:0]         stage,
  output logic                  rd_en,
  output logic [8*LOGN-1:0]     rd_addr,
  output logic [8*LOGN-1:0]     tf_exp,
  output logic                  wr_en,
  output logic [8*LOGN-1:0]     wr_addr
);

  localparam int N  = 1 << LOGN;
  localparam int BW = (LOGN > 3) ? LOGN - 3 : 1;
  localparam int D  = RD_LAT + PIPE_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = LANES * LOGN;

  localparam logic [BW-1:0] LAST_B  = BW'(N / LANES - 1);
  localparam logic [SW-1:0] LAST_S  = SW'(STAGES - 1);
  localparam logic [DW-1:0] LAST_D  = DW'(D - 1);

  ntt_state_e    state_r, state_nxt_s;
  logic [SW-1:0] stage_r, stage_nxt_s;
  logic [BW-1:0] b_r, b_nxt_s;
  logic [DW-1:0] dcnt_r, dcnt_nxt_s;
  logic [AW-1:0] rd_addr_r, tf_exp_r, addr_nxt_s, tf_nxt_s;
  logic          busy_r, done_r;
  logic [31:0]   s32_s, b32_s, sh_s, span_s, j_s, g_s, base_s;

  // next-state and counter sequencing; stall freezes everything except FIN
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    b_nxt_s     = b_r;
    dcnt_nxt_s  = dcnt_r;
    case (state_r)
      IDLE: begin
        if (start && !stall) begin
          state_nxt_s = RUN;
          stage_nxt_s = '0;
          b_nxt_s     = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (stall) begin
          state_nxt_s = RUN;
        end else if (b_r == LAST_B) begin
          state_nxt_s = DRAIN;
          dcnt_nxt_s  = '0;
        end else begin
          b_nxt_s = b_r + BW'(1);
        end
      end
      DRAIN: begin
        if (stall) begin
          state_nxt_s = DRAIN;
        end else if (dcnt_r != LAST_D) begin
          dcnt_nxt_s = dcnt_r + DW'(1);
        end else if (stage_r == LAST_S) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
          stage_nxt_s = stage_r + SW'(1);
          b_nxt_s     = '0;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // butterfly index decomposition for the next issue: span = 2^sh, j = b & (span-1), g = b >> sh
  always_comb begin
    s32_s      = 32'(stage_nxt_s);
    b32_s      = 32'(b_nxt_s);
    sh_s       = 32'(LOGN) - 32'(LANE_LOG) * (s32_s + 32'd1);
    span_s     = 32'd1 << sh_s;
    j_s        = b32_s & (span_s - 32'd1);
    g_s        = b32_s >> sh_s;
    base_s     = (g_s << (sh_s + 32'(LANE_LOG))) | j_s;
    addr_nxt_s = '0;
    tf_nxt_s   = '0;
    if (state_nxt_s == RUN) begin
      for (int k = 0; k < LANES; k++) begin
        addr_nxt_s[k*LOGN +: LOGN] = LOGN'(base_s + (32'(k) << sh_s));
        tf_nxt_s[k*LOGN +: LOGN]   = LOGN'(tf_exponent(32'(k), j_s, s32_s, LOGN));
      end
    end else begin
      addr_nxt_s = '0;
      tf_nxt_s   = '0;
    end
  end

  // state, counters and registered issue outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      stage_r   <= '0;
      b_r       <= '0;
      dcnt_r    <= '0;
      rd_addr_r <= '0;
      tf_exp_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      stage_r   <= stage_nxt_s;
      b_r       <= b_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
      rd_addr_r <= addr_nxt_s;
      tf_exp_r  <= tf_nxt_s;
      busy_r    <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
      done_r    <= (state_nxt_s == FIN);
    end
  end

  assign rd_en   = (state_r == RUN) & ~stall;
  assign rd_addr = rd_addr_r;
  assign tf_exp  = tf_exp_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign stage   = stage_r;

  ntt_addr_delay #(.DEPTH(D), .W(AW)) u_wr_delay (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (rd_en),
    .in_data   (rd_addr_r),
    .out_valid (wr_en),
    .out_data  (wr_addr)
  );

endmodule

// File: tb/tb_radix8_ntt_ctrl.sv
// Scoreboard bench: stimulus pushes expected issues/done times, one monitor
// process pops and compares whenever the DUTs present outputs.
`timescale 1ns/1ps
module tb_radix8_ntt_ctrl;

  logic clk = 1'b0;
  logic rst, start, stall, start9;
  logic stall9 = 1'b0;

  logic busy, done, rd_en, wr_en;
  logic [0:0]  stage;
  logic [47:0] rd_addr, tf_exp, wr_addr;
  logic busy9, done9, rd_en9, wr_en9;
  logic [1:0]  stage9;
  logic [71:0] rd_addr9, tf_exp9, wr_addr9;

  radix8_ntt_ctrl #(.LOGN(6), .RD_LAT(1), .PIPE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr(rd_addr), .tf_exp(tf_exp),
    .wr_en(wr_en), .wr_addr(wr_addr));

  radix8_ntt_ctrl #(.LOGN(9), .RD_LAT(1), .PIPE_LAT(1)) dut9 (
    .clk(clk), .rst(rst), .start(start9), .stall(stall9), .busy(busy9), .done(done9),
    .stage(stage9), .rd_en(rd_en9), .rd_addr(rd_addr9), .tf_exp(tf_exp9),
    .wr_en(wr_en9), .wr_addr(wr_addr9));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [71:0] exp_a6[$], exp_t6[$], exp_a9[$], exp_t9[$];
  logic [71:0] log_a6[$], log_t6[$], log_a9[$], log_t9[$];
  int exp_d6[$], exp_d9[$];
  string chk_name[$];
  logic [71:0] chk_act[$], chk_exp[$];

  typedef struct packed { logic en; logic [47:0] a; } hist_t;
  hist_t hist[$];

  int rd6_cnt = 0, wr6_cnt = 0, rd9_cnt = 0, wr9_cnt = 0;
  int done_seen6 = 0, done_seen9 = 0;

  // reference model written with plain division/modulo
  function automatic logic [71:0] m_addr(input int logn, input int s, input int b);
    int n, span, j, g;
    logic [71:0] r;
    n = 1 << logn; span = n / (8 ** (s + 1)); j = b % span; g = b / span; r = '0;
    for (int k = 0; k < 8; k++) r = r | (72'(g * 8 * span + j + k * span) << (k * logn));
    return r;
  endfunction

  function automatic logic [71:0] m_tf(input int logn, input int s, input int b);
    int n, span, j;
    logic [71:0] r;
    n = 1 << logn; span = n / (8 ** (s + 1)); j = b % span; r = '0;
    for (int k = 0; k < 8; k++) r = r | (72'((k * j * (8 ** s)) % n) << (k * logn));
    return r;
  endfunction

  // packs the arithmetic progression first, first+step, ... into 8 lanes
  function automatic logic [71:0] pack_ap(input int first, input int step, input int logn);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = r | (72'(first + k * step) << (k * logn));
    return r;
  endfunction

  task automatic push_run(input bit nine);
    int logn, stages;
    logn = nine ? 9 : 6; stages = logn / 3;
    for (int s = 0; s < stages; s++)
      for (int b = 0; b < (1 << logn) / 8; b++) begin
        if (nine) begin exp_a9.push_back(m_addr(logn, s, b)); exp_t9.push_back(m_tf(logn, s, b)); end
        else      begin exp_a6.push_back(m_addr(logn, s, b)); exp_t6.push_back(m_tf(logn, s, b)); end
      end
  endtask

  task automatic push_chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    chk_name.push_back(name); chk_act.push_back(act); chk_exp.push_back(expv);
  endtask

  task automatic at_cyc(input int t);
    while (cyc != t) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(output int e);
    @(posedge clk); #1; start = 1'b1; e = cyc;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done6(input int target, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (done_seen6 >= target) break;
      @(posedge clk); #1;
    end
    push_chk(name, 72'(done_seen6 >= target), 72'd1);
  endtask

  // monitor / scoreboard: every comparison is made here
  logic  exp_we;
  logic [47:0] exp_wa;
  logic [71:0] ea, et;
  always @(negedge clk) begin
    while (chk_name.size() > 0) begin
      total++;
      if (chk_act[0] !== chk_exp[0]) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", chk_name[0], chk_act[0], chk_exp[0]);
      end
      void'(chk_name.pop_front()); void'(chk_act.pop_front()); void'(chk_exp.pop_front());
    end
    if (rst) begin
      hist.delete();
    end else begin
      if (stall) begin
        total++;
        if (rd_en || wr_en) begin
          bad++; $display("FAIL stall_quiet: got rd_en=%0b wr_en=%0b want 0 0", rd_en, wr_en);
        end
      end else begin
        exp_we = (hist.size() >= 2) ? hist[hist.size() - 2].en : 1'b0;
        exp_wa = (hist.size() >= 2) ? hist[hist.size() - 2].a  : 48'd0;
        if (wr_en || exp_we) begin
          total++;
          if (wr_en !== exp_we || (exp_we && wr_addr !== exp_wa)) begin
            bad++;
            $display("FAIL wr_replay: got en=%0b addr=%0h want en=%0b addr=%0h", wr_en, wr_addr, exp_we, exp_wa);
          end
        end
        if (wr_en) wr6_cnt++;
        if (rd_en) begin
          rd6_cnt++; log_a6.push_back(72'(rd_addr)); log_t6.push_back(72'(tf_exp));
          total++;
          if (exp_a6.size() == 0) begin
            bad++; $display("FAIL rd_unexpected: got addr=%0h want no issue", rd_addr);
          end else begin
            ea = exp_a6.pop_front(); et = exp_t6.pop_front();
            if (72'(rd_addr) !== ea || 72'(tf_exp) !== et) begin
              bad++;
              $display("FAIL rd_issue: got addr=%0h tf=%0h want addr=%0h tf=%0h", rd_addr, tf_exp, ea, et);
            end
          end
        end
        hist.push_back({rd_en, rd_addr});
        if (hist.size() > 3) void'(hist.pop_front());
      end
      if (done) begin
        done_seen6++; total++;
        if (exp_d6.size() == 0) begin
          bad++; $display("FAIL done_unexpected: got done at %0d want none", cyc);
        end else if (exp_d6[0] != cyc) begin
          bad++; $display("FAIL done_time: got %0d want %0d", cyc, exp_d6[0]);
          void'(exp_d6.pop_front());
        end else begin
          void'(exp_d6.pop_front());
        end
      end
      if (wr_en9) wr9_cnt++;
      if (rd_en9) begin
        rd9_cnt++; log_a9.push_back(rd_addr9); log_t9.push_back(tf_exp9);
        total++;
        if (exp_a9.size() == 0) begin
          bad++; $display("FAIL rd9_unexpected: got addr=%0h want no issue", rd_addr9);
        end else begin
          ea = exp_a9.pop_front(); et = exp_t9.pop_front();
          if (rd_addr9 !== ea || tf_exp9 !== et) begin
            bad++;
            $display("FAIL rd9_issue: got addr=%0h tf=%0h want addr=%0h tf=%0h", rd_addr9, tf_exp9, ea, et);
          end
        end
      end
      if (done9) begin
        done_seen9++; total++;
        if (exp_d9.size() == 0 || exp_d9[0] != cyc) begin
          bad++; $display("FAIL done9_time: got %0d want %0d", cyc, (exp_d9.size() > 0) ? exp_d9[0] : -1);
        end
        if (exp_d9.size() > 0) void'(exp_d9.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, brd, bwr, blog, bd;
    rst = 1'b1; start = 1'b0; stall = 1'b0; start9 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    push_chk("rst_busy", 72'(busy), 72'd0);
    push_chk("rst_done", 72'(done), 72'd0);
    push_chk("rst_rd_en", 72'(rd_en), 72'd0);
    push_chk("rst_wr_en", 72'(wr_en), 72'd0);
    push_chk("rst_stage", 72'(stage), 72'd0);
    push_chk("rst_rd_addr", 72'(rd_addr), 72'd0);
    push_chk("rst_tf_exp", 72'(tf_exp), 72'd0);
    push_chk("rst_wr_addr", 72'(wr_addr), 72'd0);

    // plain run, LOGN=6
    brd = rd6_cnt; bwr = wr6_cnt; blog = log_a6.size(); bd = done_seen6;
    push_run(1'b0);
    do_start(e);
    exp_d6.push_back(e + 21);
    @(negedge clk);
    push_chk("c1_busy", 72'(busy), 72'd1);
    push_chk("c1_rd_en", 72'(rd_en), 72'd1);
    at_cyc(e + 9); @(negedge clk);
    push_chk("drain_busy", 72'(busy), 72'd1);
    push_chk("drain_rd_en", 72'(rd_en), 72'd0);
    at_cyc(e + 11); @(negedge clk);
    push_chk("s1_stage", 72'(stage), 72'd1);
    wait_done6(bd + 1, 40, "run1_done_seen");
    push_chk("run1_rd_cnt", 72'(rd6_cnt - brd), 72'd16);
    push_chk("run1_wr_cnt", 72'(wr6_cnt - bwr), 72'd16);
    push_chk("s0b0_addr", log_a6[blog + 0], pack_ap(0, 8, 6));
    push_chk("s0b0_tf", log_t6[blog + 0], 72'd0);
    push_chk("s0b3_addr", log_a6[blog + 3], pack_ap(3, 8, 6));
    push_chk("s0b3_tf", log_t6[blog + 3], pack_ap(0, 3, 6));
    push_chk("s1b5_addr", log_a6[blog + 13], pack_ap(40, 1, 6));
    push_chk("s1b5_tf", log_t6[blog + 13], 72'd0);

    // LOGN=9 run
    brd = rd9_cnt; bwr = wr9_cnt; blog = log_a9.size(); bd = done_seen9;
    push_run(1'b1);
    @(posedge clk); #1; start9 = 1'b1; e = cyc;
    exp_d9.push_back(e + 199);
    @(posedge clk); #1; start9 = 1'b0;
    for (int i = 0; i < 260 && done_seen9 == bd; i++) begin @(posedge clk); #1; end
    push_chk("run9_done_seen", 72'(done_seen9 > bd), 72'd1);
    push_chk("run9_rd_cnt", 72'(rd9_cnt - brd), 72'd192);
    push_chk("run9_wr_cnt", 72'(wr9_cnt - bwr), 72'd192);
    push_chk("l9_s1b13_addr", log_a9[blog + 77], pack_ap(69, 8, 9));
    push_chk("l9_s1b13_tf", log_t9[blog + 77], pack_ap(0, 40, 9));

    // stall 5 cycles mid-RUN and 3 in DRAIN
    brd = rd6_cnt; bwr = wr6_cnt; bd = done_seen6;
    push_run(1'b0);
    do_start(e);
    exp_d6.push_back(e + 29);
    at_cyc(e + 4);  stall = 1'b1;
    at_cyc(e + 9);  stall = 1'b0;
    at_cyc(e + 15); stall = 1'b1;
    at_cyc(e + 18); stall = 1'b0;
    wait_done6(bd + 1, 40, "stall_done_seen");
    push_chk("stall_rd_cnt", 72'(rd6_cnt - brd), 72'd16);
    push_chk("stall_wr_cnt", 72'(wr6_cnt - bwr), 72'd16);

    // reset during stage 1, then a clean rerun
    bd = done_seen6;
    push_run(1'b0);
    do_start(e);
    at_cyc(e + 13);
    rst = 1'b1;
    exp_a6.delete(); exp_t6.delete(); exp_d6.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    push_chk("abort_rd_en", 72'(rd_en), 72'd0);
    push_chk("abort_wr_en", 72'(wr_en), 72'd0);
    push_chk("abort_busy", 72'(busy), 72'd0);
    push_chk("abort_stage", 72'(stage), 72'd0);
    push_chk("abort_rd_addr", 72'(rd_addr), 72'd0);
    push_chk("abort_wr_addr", 72'(wr_addr), 72'd0);
    repeat (20) @(posedge clk);
    #1 push_chk("abort_no_done", 72'(done_seen6 - bd), 72'd0);
    brd = rd6_cnt; bwr = wr6_cnt; blog = log_a6.size(); bd = done_seen6;
    push_run(1'b0);
    do_start(e);
    exp_d6.push_back(e + 21);
    wait_done6(bd + 1, 40, "rerun_done_seen");
    push_chk("rerun_rd_cnt", 72'(rd6_cnt - brd), 72'd16);
    push_chk("rerun_s0b0_addr", log_a6[blog], pack_ap(0, 8, 6));

    // start held high across two back-to-back transforms
    brd = rd6_cnt; bwr = wr6_cnt; bd = done_seen6;
    push_run(1'b0); push_run(1'b0);
    @(posedge clk); #1; start = 1'b1; e = cyc;
    exp_d6.push_back(e + 21);
    exp_d6.push_back(e + 43);
    at_cyc(e + 23); start = 1'b0;
    wait_done6(bd + 2, 60, "held_done_seen");
    push_chk("held_rd_cnt", 72'(rd6_cnt - brd), 72'd32);
    push_chk("held_wr_cnt", 72'(wr6_cnt - bwr), 72'd32);
    push_chk("held_exp_empty", 72'(exp_a6.size()), 72'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radix8_ntt_ctrl.md
Name: radix8_ntt_ctrl

Overview:
Sequencer for the radix-8 DIF NTT butterfly datapath. Runs an in-place N-point NTT (N = 8^STAGES) over a memory that supplies 8 words per cycle. Issues one butterfly per cycle: 8 read addresses plus 8 twiddle exponents for tf0..tf7. Replays the addresses as write addresses after the fixed read and datapath latency, and drains between stages so that stage s+1 never reads data stage s has not yet written.

Parameters:
LOGN, 9, log2 of transform size. Must be a multiple of 3, so N = 2^LOGN and STAGES = LOGN/3 (derived localparam).
RD_LAT, 1, memory read latency in cycles (rd_en to data at the butterfly inputs).
PIPE_LAT, 1, butterfly plus modred_multiplier_v2 latency in cycles. Write delay D = RD_LAT + PIPE_LAT (D ≥ 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a transform; sampled only in IDLE
stall  in  1  freeze everything (issue, delay line, counters)
busy  out  1  transform in progress
done  out  1  one-cycle pulse after the final write
stage  out  ceil(log2(STAGES))  current stage index
rd_en  out  1  butterfly read issue
rd_addr  out  8*LOGN  element indices, lane k at [k*LOGN +: LOGN]
tf_exp  out  8*LOGN  twiddle exponents, lane k drives tf_k lookup
wr_en  out  1  butterfly write-back
wr_addr  out  8*LOGN  write indices, lane k aligned with output Ak

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE. busy, done, rd_en and wr_en are 0. rd_addr, tf_exp, wr_addr and stage are 0. The delay line is cleared.
- Reset mid-operation: aborts immediately. No further rd_en or wr_en, and done does not pulse.
- States:
  - IDLE: when start=1, go to RUN with stage=0 and b=0.
  - RUN: each non-stalled cycle, issue butterfly b. After b = N/8-1, go to DRAIN.
  - DRAIN: wait D non-stalled cycles. Then either go to RUN with stage+1 and b=0, or, if this is the last stage, go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- busy = 1 in RUN and DRAIN.
- start is ignored outside IDLE.
- Butterfly b of stage s:
  - span = N >> 3(s+1); j = b mod span; g = b div span.
  - base = g*8*span + j.
  - rd_addr lane k = base + k*span.
  - tf_exp lane k = (k*j*8^s) mod N, i.e. truncated to LOGN bits.
  - All index arithmetic uses shifts and masks only; no dividers.
- rd_en = 1 exactly in non-stalled RUN cycles. rd_addr and tf_exp are registered outputs, valid with rd_en.
- Write-back: wr_en and wr_addr equal rd_en and rd_addr delayed by D non-stalled cycles (shift register of depth D). tf_exp is not delayed; the twiddle ROM latency is absorbed in RD_LAT.
- stall=1:
  - rd_en=0 and wr_en=0.
  - Counters, state and delay line hold.
  - The datapath pipeline must be stalled with the same signal (system requirement).
- Timing without stall: stage period is N/8 + D cycles. With start accepted at edge 0:
  - first rd_en in cycle 1;
  - done in cycle STAGES*(N/8 + D) + 1.
- A new start is accepted in the cycle after done.

Decomposition:
- Package radix8_ntt_pkg holds:
  - state enum (IDLE, RUN, DRAIN, FIN);
  - lane-slice helper constants;
  - function tf_exponent(k, j, s, LOGN).
- One sub-module: ntt_addr_delay, a parameterised valid+data shift register of depth D with hold (stall) and sync clear. It is used for wr_en and wr_addr.

Test Plan:
- LOGN=6, D=2, start pulse -> stage 0, b=0: rd_addr = {0,8,16,…,56}, tf_exp all 0; b=3: rd_addr = {3,11,…,59}, tf_exp = {0,3,6,9,12,15,18,21}.
- Same configuration, stage 1, b=5 -> rd_addr = {40..47}, tf_exp all 0. done in cycle 21, rd_en count = 16, wr_en count = 16, each wr_addr equal to the rd_addr issued 2 cycles earlier.
- LOGN=9, stage 1, b=13 (span=8, j=5, g=1) -> rd_addr = {69,77,…,125}, tf_exp lane k = 40k mod 512 → lane 7 = 280.
- stall held for 5 cycles mid-RUN and 3 cycles in DRAIN -> no rd_en or wr_en while stalled, address sequence unchanged, done delayed exactly 8 cycles.
- rst asserted in stage 1 -> next cycle all outputs 0, no done. A subsequent start reproduces the full sequence from stage 0, b=0.
- start held high continuously -> start is ignored while busy, a new transform begins in the cycle after done, and there is no overlap of wr_en from the prior run.
